// File: rtl/mem_arb_pkg.sv
// Shared definitions for the serial-engine / processor RAM arbiter:
// FSM state encoding, owner identifiers and parameter defaults.
package mem_arb_pkg;

  localparam int unsigned HOLD_MAX_DEF = 64;
  localparam int unsigned CNT_W_DEF    = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETTLE  = 3'd1;
  localparam logic [2:0] ST_TX_OWN  = 3'd2;
  localparam logic [2:0] ST_RX_OWN  = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  localparam logic SRC_TX = 1'b0;
  localparam logic SRC_RX = 1'b1;

endpackage

// File: rtl/arb_hold_timer.sv
// Saturating ownership-hold counter; flags the cycle in which the current
// owner completes its HOLD_MAX-th cycle of ownership.
module arb_hold_timer
  import mem_arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = HOLD_MAX_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expire
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && count != CNT_MAX) begin
      count <= count + 1'b1;
    end
  end

  // Count holds completed owner cycles, so the HOLD_MAX-th cycle is the one
  // that starts with HOLD_MAX-1 already counted.
  assign expire = inc && (count >= LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Shared RAM arbiter: processor owns the RAM by default; TX/RX serial engines
// win it round-robin, with a settle cycle for the mux and a hold timeout.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = HOLD_MAX_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tx_req,
  input  logic rx_req,
  input  logic m_lock,
  output logic tx_en,
  output logic rx_en,
  output logic tx_gnt,
  output logic rx_gnt,
  output logic m_gnt,
  output logic preempt
);

  logic [2:0] state, state_nx;
  logic       cur, cur_nx;
  logic       last, last_nx;
  logic       preempt_nx;
  logic       go;
  logic       pick_rx;
  logic       owning;
  logic       expire;

  assign pick_rx = rx_req && (!tx_req || last == SRC_TX);
  assign go      = (state == ST_IDLE) && !m_lock && (tx_req || rx_req);
  assign owning  = (state == ST_TX_OWN) || (state == ST_RX_OWN);

  arb_hold_timer #(
    .HOLD_MAX (HOLD_MAX),
    .CNT_W    (CNT_W)
  ) u_hold (
    .clk    (clk),
    .rst    (rst),
    .clear  (go),
    .inc    (owning),
    .expire (expire)
  );

  always_comb begin
    state_nx   = state;
    cur_nx     = cur;
    last_nx    = last;
    preempt_nx = 1'b0;
    case (state)
      ST_IDLE: begin
        if (go) begin
          state_nx = ST_SETTLE;
          cur_nx   = pick_rx ? SRC_RX : SRC_TX;
        end
      end
      ST_SETTLE: state_nx = (cur == SRC_RX) ? ST_RX_OWN : ST_TX_OWN;
      ST_TX_OWN: begin
        if (!tx_req) begin
          state_nx = ST_RELEASE;
        end else if (expire && rx_req) begin
          state_nx   = ST_RELEASE;
          preempt_nx = 1'b1;
        end
      end
      ST_RX_OWN: begin
        if (!rx_req) begin
          state_nx = ST_RELEASE;
        end else if (expire && tx_req) begin
          state_nx   = ST_RELEASE;
          preempt_nx = 1'b1;
        end
      end
      ST_RELEASE: begin
        state_nx = ST_IDLE;
        last_nx  = cur;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cur     <= SRC_TX;
      last    <= SRC_RX;
      preempt <= 1'b0;
    end else begin
      state   <= state_nx;
      cur     <= cur_nx;
      last    <= last_nx;
      preempt <= preempt_nx;
    end
  end

  // Outputs decode the registered state only, so an async reset clears them
  // immediately and the two enables can never overlap.
  assign tx_en  = (state == ST_TX_OWN) || (state == ST_SETTLE && cur == SRC_TX);
  assign rx_en  = (state == ST_RX_OWN) || (state == ST_SETTLE && cur == SRC_RX);
  assign tx_gnt = (state == ST_TX_OWN);
  assign rx_gnt = (state == ST_RX_OWN);
  assign m_gnt  = (state == ST_IDLE) || (state == ST_RELEASE);

endmodule
